// File: rtl/cpu_defs.sv
// Shared definitions for the P7 execute stage: MDU op encodings,
// default MDU sizing, and the MDU sequencer state type.
package cpu_defs;

  localparam int MDU_WIDTH_DEF      = 32;
  localparam int MDU_MUL_CYCLES_DEF = 5;
  localparam int MDU_DIV_CYCLES_DEF = 10;

  typedef enum logic [2:0] {
    MDU_MULT  = 3'd0,
    MDU_MULTU = 3'd1,
    MDU_DIV   = 3'd2,
    MDU_DIVU  = 3'd3,
    MDU_MTHI  = 3'd4,
    MDU_MTLO  = 3'd5
  } mdu_op_e;

  // What the sequencer is waiting on; ST_IDLE whenever busy is low.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2
  } mdu_state_e;

endpackage

// File: rtl/mdu_seq_if.sv
// Execute-stage <-> MDU bundle.
// Handshake: start is the valid, ~busy is the ready, and flush vetoes the
// transfer in the same cycle. An instruction is taken on a rising edge only
// when start & ~flush & ~busy; otherwise the inputs are ignored entirely.
// hi/lo are always-readable register outputs; state is a debug view.
interface mdu_seq_if #(
  parameter int WIDTH = cpu_defs::MDU_WIDTH_DEF
);
  import cpu_defs::*;

  logic             start;
  logic [2:0]       mdu_op;
  logic [WIDTH-1:0] src_a;
  logic [WIDTH-1:0] src_b;
  logic             flush;
  logic             busy;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  mdu_state_e       state;

  modport master (
    output start, mdu_op, src_a, src_b, flush,
    input  busy, hi, lo, state
  );

  modport slave (
    input  start, mdu_op, src_a, src_b, flush,
    output busy, hi, lo, state
  );

endinterface

// File: rtl/mdu_div_core.sv
// Combinational divide datapath: magnitude divide, then sign fix-up so the
// quotient truncates toward zero and the remainder follows the dividend.
// Divide-by-zero and signed min/-1 overflow produce fixed MIPS-style results.
module mdu_div_core #(
  parameter int WIDTH = cpu_defs::MDU_WIDTH_DEF
) (
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  input  logic             is_signed,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  localparam logic [WIDTH-1:0] MIN_INT = {1'b1, {(WIDTH-1){1'b0}}};

  logic             a_neg;
  logic             b_neg;
  logic [WIDTH-1:0] mag_a;
  logic [WIDTH-1:0] mag_b;
  logic [WIDTH-1:0] q_mag;
  logic [WIDTH-1:0] r_mag;
  logic             div_zero;
  logic             overflow;

  assign a_neg    = is_signed & dividend[WIDTH-1];
  assign b_neg    = is_signed & divisor[WIDTH-1];
  assign mag_a    = a_neg ? ('0 - dividend) : dividend;
  assign mag_b    = b_neg ? ('0 - divisor) : divisor;
  assign div_zero = (divisor == '0);
  assign overflow = is_signed & (dividend == MIN_INT) & (divisor == '1);

  // Magnitude divide; the zero-divisor path is guarded so it never divides by 0.
  always_comb begin
    q_mag = '0;
    r_mag = '0;
    if (!div_zero) begin
      q_mag = mag_a / mag_b;
      r_mag = mag_a % mag_b;
    end
  end

  // Sign fix-up and special cases.
  always_comb begin
    quotient  = (a_neg ^ b_neg) ? ('0 - q_mag) : q_mag;
    remainder = a_neg ? ('0 - r_mag) : r_mag;
    if (div_zero) begin
      quotient  = '1;
      remainder = dividend;
    end else if (overflow) begin
      quotient  = MIN_INT;
      remainder = '0;
    end
  end

endmodule

// File: rtl/mdu_seq.sv
// Multi-cycle multiply/divide unit owning HI/LO. The result is computed at
// accept and held in a pending register; a down-counter models the latency
// and HI/LO are written together on the edge where it reaches zero.
module mdu_seq
  import cpu_defs::*;
#(
  parameter int WIDTH      = MDU_WIDTH_DEF,
  parameter int MUL_CYCLES = MDU_MUL_CYCLES_DEF,
  parameter int DIV_CYCLES = MDU_DIV_CYCLES_DEF
) (
  input  logic     clk,
  input  logic     reset_n,
  mdu_seq_if.slave bus
);

  localparam int MAX_CYCLES = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  localparam int CW         = $clog2(MAX_CYCLES + 1);

  mdu_op_e            op;
  logic               accept;
  logic [CW-1:0]      cnt_q;
  logic [WIDTH-1:0]   hi_q;
  logic [WIDTH-1:0]   lo_q;
  logic [WIDTH-1:0]   res_hi_q;
  logic [WIDTH-1:0]   res_lo_q;
  mdu_state_e         state_q;
  logic [2*WIDTH-1:0] ext_a;
  logic [2*WIDTH-1:0] ext_b;
  logic [2*WIDTH-1:0] product;
  logic [WIDTH-1:0]   quotient;
  logic [WIDTH-1:0]   remainder;

  assign op     = mdu_op_e'(bus.mdu_op);
  assign accept = bus.start & ~bus.flush & ~bus.busy;

  // Sign- or zero-extend to 2*WIDTH; the low 2*WIDTH bits of the extended
  // product are then the exact signed or unsigned product.
  assign ext_a   = (op == MDU_MULT) ? {{WIDTH{bus.src_a[WIDTH-1]}}, bus.src_a}
                                    : {{WIDTH{1'b0}}, bus.src_a};
  assign ext_b   = (op == MDU_MULT) ? {{WIDTH{bus.src_b[WIDTH-1]}}, bus.src_b}
                                    : {{WIDTH{1'b0}}, bus.src_b};
  assign product = ext_a * ext_b;

  mdu_div_core #(.WIDTH(WIDTH)) u_div (
    .dividend  (bus.src_a),
    .divisor   (bus.src_b),
    .is_signed (op == MDU_DIV),
    .quotient  (quotient),
    .remainder (remainder)
  );

  // Sequencer: count down an in-flight op and commit on the last edge,
  // otherwise take a newly accepted instruction.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      res_hi_q <= '0;
      res_lo_q <= '0;
      state_q  <= ST_IDLE;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - CW'(1);
      if (cnt_q == CW'(1)) begin
        hi_q    <= res_hi_q;
        lo_q    <= res_lo_q;
        state_q <= ST_IDLE;
      end
    end else if (accept) begin
      case (op)
        MDU_MULT, MDU_MULTU: begin
          res_hi_q <= product[2*WIDTH-1:WIDTH];
          res_lo_q <= product[WIDTH-1:0];
          cnt_q    <= CW'(MUL_CYCLES);
          state_q  <= ST_MUL;
        end
        MDU_DIV, MDU_DIVU: begin
          res_hi_q <= remainder;
          res_lo_q <= quotient;
          cnt_q    <= CW'(DIV_CYCLES);
          state_q  <= ST_DIV;
        end
        MDU_MTHI: hi_q <= bus.src_a;
        MDU_MTLO: lo_q <= bus.src_a;
        default: ;
      endcase
    end
  end

  assign bus.busy  = (cnt_q != '0);
  assign bus.hi    = hi_q;
  assign bus.lo    = lo_q;
  assign bus.state = state_q;

endmodule
